// File: rtl/float_to_int.sv
// float_to_int: three-stage pipelined converter from {s, e, f} float to signed integer.
// Define FLOAT_TO_INT_ROUND_EN for round-to-nearest-even; otherwise truncates toward zero.
module float_to_int #(
  parameter int               E_bit = 8,
  parameter int               F_bit = 23,
  parameter int               I_bit = 32,
  parameter logic [E_bit-1:0] E_ref = {1'b0, {(E_bit-1){1'b1}}},
  parameter logic [E_bit-1:0] E_max = {E_bit{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [E_bit+F_bit:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [I_bit-1:0]     out_data,
  output logic                 out_ovf,
  output logic                 out_inv
);

  localparam int XW = E_bit + 1;
  localparam int MW = (I_bit > F_bit + 1) ? I_bit : F_bit + 1;
  localparam logic signed [XW-1:0] X_BIG   = XW'(I_bit - 1);
  localparam logic signed [XW-1:0] X_FRC   = XW'(F_bit);
  localparam logic [I_bit-1:0]     INT_MAX = {1'b0, {(I_bit-1){1'b1}}};
  localparam logic [I_bit-1:0]     INT_MIN = {1'b1, {(I_bit-1){1'b0}}};

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_FRAC,
    CLS_NORM,
    CLS_BIG,
    CLS_INF,
    CLS_NAN
  } cls_t;

  logic adv;
  logic out_valid_reg;

  // Global stall: every stage advances only when the output slot frees up.
  assign adv       = !out_valid_reg || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_reg;

  // ---------------- S0: decode / classify ----------------
  logic                 sgn_in;
  logic [E_bit-1:0]     exp_in;
  logic [F_bit-1:0]     frac_in;
  logic signed [XW-1:0] x_next;
  logic                 exact_min0_next;
  cls_t                 cls0_next;

  assign sgn_in          = in_data[E_bit+F_bit];
  assign exp_in          = in_data[E_bit+F_bit-1:F_bit];
  assign frac_in         = in_data[F_bit-1:0];
  assign x_next          = $signed({1'b0, exp_in}) - $signed({1'b0, E_ref});
  assign exact_min0_next = sgn_in && (x_next == X_BIG) && (frac_in == '0);

  always_comb begin
    cls0_next = CLS_NORM;
    if (exp_in == '0) begin
      cls0_next = CLS_ZERO;
    end else if (exp_in == E_max) begin
      cls0_next = (frac_in != '0) ? CLS_NAN : CLS_INF;
    end else if (x_next >= X_BIG) begin
      cls0_next = CLS_BIG;
    end else if (x_next[XW-1]) begin
      cls0_next = CLS_FRAC;
    end
  end

  logic                 v0_reg;
  cls_t                 cls0_reg;
  logic                 sgn0_reg;
  logic signed [XW-1:0] x0_reg;
  logic [F_bit:0]       man0_reg;
  logic                 exact_min0_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_reg         <= 1'b0;
      cls0_reg       <= CLS_ZERO;
      sgn0_reg       <= 1'b0;
      x0_reg         <= '0;
      man0_reg       <= '0;
      exact_min0_reg <= 1'b0;
    end else if (adv) begin
      v0_reg         <= in_valid;
      cls0_reg       <= cls0_next;
      sgn0_reg       <= sgn_in;
      x0_reg         <= x_next;
      man0_reg       <= {1'b1, frac_in};
      exact_min0_reg <= exact_min0_next;
    end
  end

  // ---------------- S1: align ----------------
  logic [XW-1:0]    rsh;
  logic [XW-1:0]    lsh;
  logic [MW-1:0]    lmag_w;
  logic [F_bit:0]   rmag;
  logic [I_bit-1:0] mag1_next;

  // Out-of-range shift amounts wrap to large values and shift everything out.
  assign rsh    = X_FRC - x0_reg;
  assign lsh    = x0_reg - X_FRC;
  assign lmag_w = MW'(man0_reg) << lsh;

`ifdef FLOAT_TO_INT_ROUND_EN
  localparam int SW = 2 * F_bit + 2;
  logic [SW-1:0] rsh_w;
  logic          guard1_next;
  logic          sticky1_next;

  // Extra zero bits below the mantissa catch the dropped bits; x == -1 falls out naturally.
  assign rsh_w        = {man0_reg, {(F_bit+1){1'b0}}} >> rsh;
  assign rmag         = rsh_w[SW-1:F_bit+1];
  assign guard1_next  = rsh_w[F_bit];
  assign sticky1_next = |rsh_w[F_bit-1:0];
`else
  assign rmag = man0_reg >> rsh;
`endif

  assign mag1_next = (x0_reg >= X_FRC) ? I_bit'(lmag_w) : I_bit'(MW'(rmag));

  logic             v1_reg;
  cls_t             cls1_reg;
  logic             sgn1_reg;
  logic [I_bit-1:0] mag1_reg;
  logic             exact_min1_reg;
`ifdef FLOAT_TO_INT_ROUND_EN
  logic             guard1_reg;
  logic             sticky1_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg         <= 1'b0;
      cls1_reg       <= CLS_ZERO;
      sgn1_reg       <= 1'b0;
      mag1_reg       <= '0;
      exact_min1_reg <= 1'b0;
`ifdef FLOAT_TO_INT_ROUND_EN
      guard1_reg     <= 1'b0;
      sticky1_reg    <= 1'b0;
`endif
    end else if (adv) begin
      v1_reg         <= v0_reg;
      cls1_reg       <= cls0_reg;
      sgn1_reg       <= sgn0_reg;
      mag1_reg       <= mag1_next;
      exact_min1_reg <= exact_min0_reg;
`ifdef FLOAT_TO_INT_ROUND_EN
      guard1_reg     <= guard1_next;
      sticky1_reg    <= sticky1_next;
`endif
    end
  end

  // ---------------- S2: round / sign / saturate ----------------
  logic [I_bit-1:0] data2_next;
  logic             ovf2_next;
  logic             inv2_next;

`ifdef FLOAT_TO_INT_ROUND_EN
  logic             round_inc;
  logic [I_bit-1:0] mag_rnd;

  assign round_inc = guard1_reg & (sticky1_reg | mag1_reg[0]);
  assign mag_rnd   = mag1_reg + I_bit'(round_inc);
`endif

  always_comb begin
    data2_next = '0;
    ovf2_next  = 1'b0;
    inv2_next  = 1'b0;
    case (cls1_reg)
`ifdef FLOAT_TO_INT_ROUND_EN
      CLS_NORM, CLS_FRAC: begin
        // Rounding up to 2^(I_bit-1) is only representable when negative.
        if (mag_rnd[I_bit-1] && !sgn1_reg) begin
          data2_next = INT_MAX;
          ovf2_next  = 1'b1;
        end else begin
          data2_next = sgn1_reg ? ('0 - mag_rnd) : mag_rnd;
        end
      end
`else
      CLS_NORM: data2_next = sgn1_reg ? ('0 - mag1_reg) : mag1_reg;
`endif
      CLS_BIG: begin
        if (exact_min1_reg) begin
          data2_next = INT_MIN;
        end else begin
          data2_next = sgn1_reg ? INT_MIN : INT_MAX;
          ovf2_next  = 1'b1;
        end
      end
      CLS_INF: begin
        data2_next = sgn1_reg ? INT_MIN : INT_MAX;
        ovf2_next  = 1'b1;
      end
      CLS_NAN: inv2_next = 1'b1;
      default: ;
    endcase
  end

  logic [I_bit-1:0] out_data_reg;
  logic             out_ovf_reg;
  logic             out_inv_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ovf_reg   <= 1'b0;
      out_inv_reg   <= 1'b0;
    end else if (adv) begin
      out_valid_reg <= v1_reg;
      out_data_reg  <= data2_next;
      out_ovf_reg   <= ovf2_next;
      out_inv_reg   <= inv2_next;
    end
  end

  assign out_data = out_data_reg;
  assign out_ovf  = out_ovf_reg;
  assign out_inv  = out_inv_reg;

endmodule

// File: tb/tb_float_to_int.sv
// tb_float_to_int: directed vector table, randomized scoreboard run, back-pressure and reset sequences.
// Expectations follow FLOAT_TO_INT_ROUND_EN when it is defined for the build.
module tb_float_to_int;

`ifdef FLOAT_TO_INT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int NRAND = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_inv;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  float_to_int dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_inv   (out_inv)
  );

  typedef struct packed {
    logic [31:0] in_w;
    logic [31:0] data;
    logic        ovf;
    logic        inv;
  } vec_t;

  vec_t        vecs[$];
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] w, input logic [31:0] d, input logic o, input logic i);
    vec_t v;
    v.in_w = w;
    v.data = d;
    v.ovf  = o;
    v.inv  = i;
    vecs.push_back(v);
  endtask

  // Exact value is m * 2^(x-23); convert with wide integer arithmetic, then range-check.
  function automatic logic [33:0] ref_model(input logic [31:0] w);
    longint m, mag, rem, half, v;
    int     e, x, sh;
    e = int'(w[30:23]);
    m = longint'({1'b1, w[22:0]});
    if (e == 0) return 34'd0;
    if (e == 255) begin
      if (w[22:0] != 23'd0) return {32'd0, 2'b01};
      return {(w[31] ? 32'h8000_0000 : 32'h7FFF_FFFF), 2'b10};
    end
    x = e - 127;
    if (x > 40) begin
      mag = 64'sd1 <<< 40;
    end else if (x >= 23) begin
      mag = m <<< (x - 23);
    end else if (x <= -2) begin
      mag = 0;
    end else begin
      sh  = 23 - x;
      mag = m >>> sh;
      if (RND) begin
        rem  = m - (mag <<< sh);
        half = 64'sd1 <<< (sh - 1);
        if (rem > half || (rem == half && mag[0])) mag = mag + 1;
      end
    end
    v = w[31] ? -mag : mag;
    if (v > 64'sd2147483647) return {32'h7FFF_FFFF, 2'b10};
    if (v < -64'sd2147483648) return {32'h8000_0000, 2'b10};
    return {v[31:0], 2'b00};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0] e;
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 6)       e = 8'($urandom_range(118, 160));
    else if (sel == 6) e = 8'd0;
    else if (sel == 7) e = 8'hFF;
    else               e = 8'($urandom);
    return {1'($urandom), e, ((sel == 9) ? 23'd0 : 23'($urandom))};
  endfunction

  task automatic send_one(input logic [31:0] w, output int lat, output logic [33:0] res);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res = {out_data, out_ovf, out_inv};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          nsent, nrecv, idx, got, stall, stale;
    bit          seen_valid, stalled;
    logic [33:0] res, expv, held;
    logic [31:0] bp_words[4];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flags", {out_ovf, out_inv}, 0);
    #1 check("rst_in_ready", in_ready, 1);

    // ---------- directed vector table ----------
    add_vec(32'hC2F60000, 32'hFFFFFF85, 0, 0);
    add_vec(32'h3FC00000, RND ? 32'd2 : 32'd1, 0, 0);
    add_vec(32'h40200000, 32'd2, 0, 0);
    add_vec(32'h3F400000, RND ? 32'd1 : 32'd0, 0, 0);
    add_vec(32'h4F000000, 32'h7FFFFFFF, 1, 0);
    add_vec(32'hCF000000, 32'h80000000, 0, 0);
    add_vec(32'h00000001, 32'd0, 0, 0);
    add_vec(32'h7FC00000, 32'd0, 0, 1);
    add_vec(32'hFF800000, 32'h80000000, 1, 0);
    add_vec(32'h80000000, 32'd0, 0, 0);
    add_vec(32'h7F800000, 32'h7FFFFFFF, 1, 0);
    add_vec(32'h3F000000, 32'd0, 0, 0);
    add_vec(32'h4EFFFFFF, 32'h7FFFFF80, 0, 0);
    add_vec(32'hCF000001, 32'h80000000, 1, 0);
    add_vec(32'h3FFFFFFF, RND ? 32'd2 : 32'd1, 0, 0);
    add_vec(32'hBFC00000, RND ? 32'hFFFFFFFE : 32'hFFFFFFFF, 0, 0);
    add_vec(32'h49742400, 32'h000F4240, 0, 0);
    add_vec(32'h3F800000, 32'd1, 0, 0);
    add_vec(32'h7FFFFFFF, 32'd0, 0, 1);
    add_vec(32'h4B000001, 32'h00800001, 0, 0);
    add_vec(32'hCEFFFFFF, 32'h80000080, 0, 0);
    add_vec(32'h3FE00000, RND ? 32'd2 : 32'd1, 0, 0);

    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      send_one(vecs[i].in_w, lat, res);
      check("latency", lat, 3);
      check("vector", res, {vecs[i].data, vecs[i].ovf, vecs[i].inv});
      $display("vec %0d in=%h out=%h ovf=%b inv=%b lat=%0d",
               i, vecs[i].in_w, res[33:2], res[1], res[0], lat);
    end

    // ---------- randomized stream against the reference model ----------
    nsent = 0; nrecv = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 3000 && nrecv < NRAND; c++) begin
      @(posedge clk); #1;
      if (stalled) check("hold", {out_valid, out_data, out_ovf, out_inv}, {1'b1, held});
      in_valid  = (nsent < NRAND) && ($urandom_range(0, 3) != 0);
      in_data   = rand_float();
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(in_data));
        nsent++;
      end
      stalled = out_valid && !out_ready;
      held    = {out_data, out_ovf, out_inv};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          expv = exp_q.pop_front();
          check("random", {out_data, out_ovf, out_inv}, expv);
          $display("rnd %0d out=%h ovf=%b inv=%b exp=%h", nrecv, out_data, out_ovf, out_inv, expv[33:2]);
        end
        nrecv++;
      end
    end
    in_valid = 1'b0;
    check("random_count", nrecv, NRAND);
    check("random_drain", exp_q.size(), 0);

    // ---------- back-pressure: 1,2,3,4 with a 2-cycle output stall ----------
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    bp_words[0] = 32'h3F800000; bp_words[1] = 32'h40000000;
    bp_words[2] = 32'h40400000; bp_words[3] = 32'h40800000;
    idx = 0; got = 0; stall = 0; seen_valid = 1'b0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(posedge clk); #1;
      in_valid = (idx < 4);
      in_data  = (idx < 4) ? bp_words[idx] : 32'd0;
      if (out_valid && !seen_valid) begin
        seen_valid = 1'b1;
        stall = 2;
      end
      out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        check("bp_in_ready", in_ready, 0);
        check("bp_hold", {out_valid, out_data}, {1'b1, 32'd1});
        stall--;
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        check("bp_order", out_data, got + 1);
        $display("bp out=%h", out_data);
        got++;
      end
    end
    in_valid = 1'b0;
    check("bp_count", got, 4);
    stale = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("bp_no_dup", stale, 0);

    // ---------- reset with three words in flight ----------
    out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b1; in_data = 32'h40A00000;
    @(posedge clk); #1; in_data = 32'h40C00000;
    @(posedge clk); #1; in_data = 32'h40E00000;
    @(posedge clk); #1; in_valid = 1'b0;
    check("pre_rst_front", {out_valid, out_data}, {1'b1, 32'd5});
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_flags", {out_ovf, out_inv}, 0);
    $display("rst pulse out_valid=%b out_data=%h", out_valid, out_data);
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("rst_no_stale", stale, 0);
    send_one(32'h41000000, lat, res);
    check("post_rst_latency", lat, 3);
    check("post_rst_data", res, {32'd8, 2'b00});
    $display("post-rst out=%h lat=%0d", res[33:2], lat);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
